imc_input_buffer: RTL and testbench
===================================

IMC_INPUT_BUFFER -- requirements
Module: imc_input_buffer

Interface
REQ-001 Parameter: WIDTH, default 16, input-vector width; equals the number of IMC wordline pairs.
REQ-002 Parameter: DEPTH, default 4, FIFO entries; power of two, minimum 2.
REQ-003 Parameter: IMC_CYCLES, default 9, cycles one IMC operation occupies the controller, from imc_en pulse to return to idle.
REQ-004 clk  input  1  sole clock; all logic on posedge.
REQ-005 reset  input  1  reset; synchronous and active-high.
REQ-006 wr_valid  input  1  upstream offers wr_data this cycle.
REQ-007 wr_data  input  WIDTH  input activation vector.
REQ-008 wr_ready  output  1  FIFO can accept a vector.
REQ-009 run  input  1  permits issuing new IMC operations.
REQ-010 ctrl_busy  input  1  controller memory-mode busy flag; blocks issue while high.
REQ-011 IB_out  output  WIDTH  vector driving the controller WL driver inputs.
REQ-012 imc_en  output  1  one-cycle IMC start request to the controller.
REQ-013 in_flight  output  1  an IMC operation is in progress.
REQ-014 fifo_count  output  log2(DEPTH)+1  occupied entries.
REQ-015 ops_done  output  8  completed IMC operations, modulo 256.

Function
REQ-016 FIFO: circular, DEPTH x WIDTH; write and read pointers wrap from DEPTH-1 to 0.
REQ-017 wr_ready = !full && !reset, combinational.
REQ-018 Push on wr_valid && wr_ready.
- While full, a push is rejected even when a pop occurs in the same cycle.
- wr_data is ignored while wr_ready is low.
REQ-019 Push and pop in the same cycle: fifo_count unchanged; both pointers advance.
REQ-020 FSM states: IDLE, ISSUE, HOLD.
REQ-021 IDLE -> ISSUE when run && !ctrl_busy && fifo_count != 0.
- On that edge, IB_out is loaded from the FIFO head.
- The head is not popped.
REQ-022 ISSUE: lasts exactly one cycle.
- imc_en = 1; in_flight = 1.
- Hold timer loaded with IMC_CYCLES-1.
- Next state: HOLD.
REQ-023 HOLD: imc_en = 0; in_flight = 1; IB_out held stable; timer decrements each cycle.
REQ-024 Leaving HOLD: in the HOLD cycle where timer == 1, pop the head, increment ops_done, and go to IDLE.
- in_flight = 0 from the next cycle.
REQ-025 Issue timing: IB_out is stable from the ISSUE cycle through the final HOLD cycle, i.e. IMC_CYCLES consecutive cycles.
- imc_en rises no more than once per operation.
REQ-026 IB_out retains the last issued vector in IDLE until the next ISSUE.
REQ-027 Back-to-back issue: minimum 1 IDLE cycle between operations.
- Period = IMC_CYCLES+1 cycles when the FIFO stays non-empty.
REQ-028 Deassertion mid-operation: run or ctrl_busy falling low or rising high during ISSUE/HOLD does not abort the operation; both only gate the IDLE->ISSUE transition.
REQ-029 Pushes during ISSUE/HOLD are accepted per REQ-018; the held entry counts as occupied until popped.
REQ-030 ops_done wraps from 255 to 0 without a flag.

Reset
REQ-031 When reset is high at a clk edge:
- state = IDLE.
- FIFO pointers = 0; fifo_count = 0.
- IB_out = 0; imc_en = 0; in_flight = 0; ops_done = 0; timer = 0.
REQ-032 Reset mid-operation (ISSUE or HOLD): the in-flight vector is discarded, with no pop increment; the FIFO is emptied.
REQ-033 FIFO storage contents need not be reset.

Verification
REQ-034 Basic op:
- Stimulus: reset, push 16'hA5A5, run = 1, ctrl_busy = 0.
- Response: imc_en high exactly 1 cycle; IB_out = 16'hA5A5 for 9 cycles; ops_done = 1; fifo_count = 0.
REQ-035 Full:
- Stimulus: run = 0, push 5 vectors.
- Response: first 4 accepted; wr_ready = 0 and fifo_count = 4 after the 4th; 5th not stored.
- Then run = 1: 4 imc_en pulses spaced 10 cycles apart; IB_out follows push order.
REQ-036 Gating:
- Stimulus: ctrl_busy = 1 with 2 entries queued, run = 1.
- Response: no imc_en until ctrl_busy falls; first pulse on the cycle after the IDLE evaluation with ctrl_busy = 0.
REQ-037 Simultaneous push/pop:
- Stimulus: DEPTH-1 entries, push on the final HOLD cycle.
- Response: fifo_count unchanged; pointers wrap correctly across index 3 -> 0.
REQ-038 Reset mid-HOLD:
- Stimulus: assert reset in the 5th HOLD cycle.
- Response: next cycle imc_en = 0, in_flight = 0, IB_out = 0, fifo_count = 0, ops_done = 0.
REQ-039 Wrap:
- Stimulus: 256 completed operations.
- Response: ops_done returns to 0.

Source files
------------

// File: rtl/imc_input_buffer.sv
// Input-activation buffer for an in-memory-compute macro: a small circular FIFO of wordline
// vectors plus an issue FSM that presents one vector to the controller per IMC operation.
// IMC_CYCLES must be at least 2 and DEPTH a power of two no smaller than 2.
module imc_input_buffer #(
  parameter int WIDTH      = 16,
  parameter int DEPTH      = 4,
  parameter int IMC_CYCLES = 9
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic                       wr_valid,
  input  logic [WIDTH-1:0]           wr_data,
  output logic                       wr_ready,
  input  logic                       run,
  input  logic                       ctrl_busy,
  output logic [WIDTH-1:0]           IB_out,
  output logic                       imc_en,
  output logic                       in_flight,
  output logic [$clog2(DEPTH):0]     fifo_count,
  output logic [7:0]                 ops_done
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = PTR_W + 1;
  localparam int TMR_W = $clog2(IMC_CYCLES + 1);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    HOLD  = 2'd2
  } state_t;

  state_t            state;
  logic [TMR_W-1:0]  timer;
  logic [WIDTH-1:0]  mem [DEPTH];
  logic [PTR_W-1:0]  wr_ptr;
  logic [PTR_W-1:0]  rd_ptr;

  logic full;
  logic empty;
  logic push;
  logic pop;
  logic start;

  function automatic logic [PTR_W-1:0] ptr_next(input logic [PTR_W-1:0] p);
    return (p == PTR_W'(DEPTH - 1)) ? '0 : p + PTR_W'(1);
  endfunction

  assign full     = (fifo_count == CNT_W'(DEPTH));
  assign empty    = (fifo_count == '0);
  // Full blocks a push even when a pop frees a slot in the same cycle.
  assign wr_ready = !full && !reset;
  assign push     = wr_valid && wr_ready;
  // The head entry stays occupied for the whole operation and is retired on the last HOLD cycle.
  assign pop      = (state == HOLD) && (timer == TMR_W'(1));
  assign start    = (state == IDLE) && run && !ctrl_busy && !empty;

  // NOTE: the vector storage has no reset; only pointers and count define which entries are valid.
  always_ff @(posedge clk) begin
    if (push) begin
      mem[wr_ptr] <= wr_data;
    end
  end

  // NOTE: every sequential block uses non-blocking assignments so all state updates see pre-edge values.
  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      fifo_count <= '0;
    end else begin
      if (push) begin
        wr_ptr <= ptr_next(wr_ptr);
      end
      if (pop) begin
        rd_ptr <= ptr_next(rd_ptr);
      end
      case ({push, pop})
        2'b10:   fifo_count <= fifo_count + CNT_W'(1);
        2'b01:   fifo_count <= fifo_count - CNT_W'(1);
        default: fifo_count <= fifo_count;
      endcase
    end
  end

  // Issue FSM: ISSUE is a single cycle, HOLD counts IMC_CYCLES-1 down to 1.
  always_ff @(posedge clk) begin
    if (reset) begin
      state     <= IDLE;
      timer     <= '0;
      IB_out    <= '0;
      imc_en    <= 1'b0;
      in_flight <= 1'b0;
      ops_done  <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (start) begin
            IB_out    <= mem[rd_ptr];
            imc_en    <= 1'b1;
            in_flight <= 1'b1;
            state     <= ISSUE;
          end
        end
        ISSUE: begin
          imc_en <= 1'b0;
          timer  <= TMR_W'(IMC_CYCLES - 1);
          state  <= HOLD;
        end
        HOLD: begin
          if (timer == TMR_W'(1)) begin
            timer     <= '0;
            in_flight <= 1'b0;
            ops_done  <= ops_done + 8'd1;
            state     <= IDLE;
          end else begin
            timer <= timer - TMR_W'(1);
          end
        end
        default: begin
          imc_en    <= 1'b0;
          in_flight <= 1'b0;
          timer     <= '0;
          state     <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_imc_input_buffer.sv
// Directed bench for imc_input_buffer: reset, single op, full FIFO, gating,
// simultaneous push/pop with pointer wrap, reset mid-HOLD and ops_done wrap.
module tb_imc_input_buffer;

  logic        clk;
  logic        reset;
  logic        wr_valid;
  logic [15:0] wr_data;
  logic        wr_ready;
  logic        run;
  logic        ctrl_busy;
  logic [15:0] IB_out;
  logic        imc_en;
  logic        in_flight;
  logic [2:0]  fifo_count;
  logic [7:0]  ops_done;

  int n_checks = 0;
  int n_errors = 0;

  int          obs_pulses;
  int          obs_flight;
  int          obs_viol;
  int          obs_at[$];
  logic [15:0] obs_vec[$];

  int exp_cnt[5] = '{1, 2, 3, 4, 4};

  imc_input_buffer #(.WIDTH(16), .DEPTH(4), .IMC_CYCLES(9)) dut (
    .clk        (clk),
    .reset      (reset),
    .wr_valid   (wr_valid),
    .wr_data    (wr_data),
    .wr_ready   (wr_ready),
    .run        (run),
    .ctrl_busy  (ctrl_busy),
    .IB_out     (IB_out),
    .imc_en     (imc_en),
    .in_flight  (in_flight),
    .fifo_count (fifo_count),
    .ops_done   (ops_done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] actual, input logic [31:0] expected);
    n_checks++;
    if (actual !== expected) begin
      n_errors++;
      $display("FAIL %s: got %0h, expected %0h", tag, actual, expected);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic push(input logic [15:0] d);
    wr_valid = 1'b1;
    wr_data  = d;
    step();
    wr_valid = 1'b0;
  endtask

  function automatic logic [31:0] vec_at(input int i);
    return (i < obs_vec.size()) ? 32'(obs_vec[i]) : 'x;
  endfunction

  function automatic logic [31:0] at_at(input int i);
    return (i < obs_at.size()) ? 32'(obs_at[i]) : 'x;
  endfunction

  // Steps n cycles recording imc_en pulses, the vector presented with each pulse,
  // in-flight cycles, and any IB_out change or imc_en while an operation is (not) active.
  task automatic observe(input int n);
    logic [15:0] prev_ib;
    logic        prev_fl;
    obs_pulses = 0;
    obs_flight = 0;
    obs_viol   = 0;
    obs_at.delete();
    obs_vec.delete();
    prev_ib = IB_out;
    prev_fl = in_flight;
    for (int i = 0; i < n; i++) begin
      step();
      if (imc_en) begin
        obs_pulses++;
        obs_at.push_back(i);
        obs_vec.push_back(IB_out);
        if (!in_flight) obs_viol++;
      end
      if (in_flight) obs_flight++;
      if (in_flight && prev_fl && (IB_out != prev_ib)) obs_viol++;
      prev_ib = IB_out;
      prev_fl = in_flight;
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int  n_ops;
    bit  seen255;
    bit  done;

    reset     = 1'b1;
    wr_valid  = 1'b0;
    wr_data   = '0;
    run       = 1'b0;
    ctrl_busy = 1'b0;
    step();
    step();

    // Reset state
    check("rst_ib_out",    32'(IB_out), 32'h0);
    check("rst_imc_en",    32'(imc_en), 32'h0);
    check("rst_in_flight", 32'(in_flight), 32'h0);
    check("rst_count",     32'(fifo_count), 32'h0);
    check("rst_ops",       32'(ops_done), 32'h0);
    check("rst_wr_ready",  32'(wr_ready), 32'h0);
    reset = 1'b0;
    #1;
    check("post_rst_wr_ready", 32'(wr_ready), 32'h1);

    // Basic operation
    run = 1'b1;
    push(16'hA5A5);
    check("basic_count_after_push", 32'(fifo_count), 32'h1);
    check("basic_no_early_en",      32'(imc_en), 32'h0);
    observe(12);
    check("basic_pulses",   32'(obs_pulses), 32'd1);
    check("basic_pulse_at", at_at(0), 32'd0);
    check("basic_vec",      vec_at(0), 32'hA5A5);
    check("basic_flight",   32'(obs_flight), 32'd9);
    check("basic_stable",   32'(obs_viol), 32'd0);
    check("basic_ops",      32'(ops_done), 32'd1);
    check("basic_count",    32'(fifo_count), 32'd0);
    check("basic_retain",   32'(IB_out), 32'hA5A5);

    // Full FIFO: fifth push rejected
    run      = 1'b0;
    wr_valid = 1'b1;
    for (int i = 0; i < 5; i++) begin
      wr_data = 16'(32'h1111 * (i + 1));
      step();
      check($sformatf("full_count_%0d", i), 32'(fifo_count), 32'(exp_cnt[i]));
      if (i == 3) check("full_wr_ready", 32'(wr_ready), 32'h0);
    end
    wr_valid = 1'b0;
    run      = 1'b1;
    observe(45);
    check("full_pulses", 32'(obs_pulses), 32'd4);
    for (int i = 0; i < 4; i++) begin
      check($sformatf("full_at_%0d", i),  at_at(i), 32'(10 * i));
      check($sformatf("full_vec_%0d", i), vec_at(i), 32'(32'h1111 * (i + 1)));
    end
    check("full_stable", 32'(obs_viol), 32'd0);
    check("full_count",  32'(fifo_count), 32'd0);
    check("full_ops",    32'(ops_done), 32'd5);

    // Gating by ctrl_busy, and no abort when run/ctrl_busy change mid-operation
    ctrl_busy = 1'b1;
    push(16'hAAAA);
    push(16'hBBBB);
    check("gate_count", 32'(fifo_count), 32'd2);
    observe(6);
    check("gate_blocked", 32'(obs_pulses), 32'd0);
    ctrl_busy = 1'b0;
    observe(3);
    check("gate_pulses", 32'(obs_pulses), 32'd1);
    check("gate_at",     at_at(0), 32'd0);
    check("gate_vec",    vec_at(0), 32'hAAAA);
    ctrl_busy = 1'b1;
    run       = 1'b0;
    observe(20);
    check("noabort_pulses", 32'(obs_pulses), 32'd0);
    check("noabort_flight", 32'(obs_flight), 32'd6);
    check("noabort_count",  32'(fifo_count), 32'd1);
    check("noabort_ops",    32'(ops_done), 32'd6);
    ctrl_busy = 1'b0;
    run       = 1'b1;
    observe(12);
    check("gate2_pulses", 32'(obs_pulses), 32'd1);
    check("gate2_vec",    vec_at(0), 32'hBBBB);
    check("gate2_ops",    32'(ops_done), 32'd7);
    check("gate2_count",  32'(fifo_count), 32'd0);

    // Simultaneous push/pop on the final HOLD cycle; pointers now sit at index 3
    run = 1'b0;
    push(16'hC001);
    push(16'hC002);
    push(16'hC003);
    check("pp_count_pre", 32'(fifo_count), 32'd3);
    run = 1'b1;
    step();
    check("pp_issue_en",  32'(imc_en), 32'h1);
    check("pp_issue_vec", 32'(IB_out), 32'hC001);
    repeat (8) step();
    check("pp_last_hold", 32'(in_flight), 32'h1);
    wr_valid = 1'b1;
    wr_data  = 16'hC004;
    step();
    wr_valid = 1'b0;
    check("pp_count_same", 32'(fifo_count), 32'd3);
    check("pp_idle",       32'(in_flight), 32'h0);
    check("pp_ops",        32'(ops_done), 32'd8);
    observe(30);
    check("pp_pulses", 32'(obs_pulses), 32'd3);
    check("pp_vec_0",  vec_at(0), 32'hC002);
    check("pp_vec_1",  vec_at(1), 32'hC003);
    check("pp_vec_2",  vec_at(2), 32'hC004);
    check("pp_at_2",   at_at(2), 32'd20);
    check("pp_count",  32'(fifo_count), 32'd0);
    check("pp_ops_end", 32'(ops_done), 32'd11);

    // Reset in the 5th HOLD cycle
    run = 1'b0;
    push(16'hD001);
    push(16'hD002);
    run = 1'b1;
    step();
    repeat (5) step();
    check("mid_in_hold", 32'(in_flight), 32'h1);
    reset = 1'b1;
    step();
    check("mid_imc_en",    32'(imc_en), 32'h0);
    check("mid_in_flight", 32'(in_flight), 32'h0);
    check("mid_ib_out",    32'(IB_out), 32'h0);
    check("mid_count",     32'(fifo_count), 32'h0);
    check("mid_ops",       32'(ops_done), 32'h0);
    check("mid_wr_ready",  32'(wr_ready), 32'h0);
    reset = 1'b0;
    #1;
    check("mid_wr_ready_rel", 32'(wr_ready), 32'h1);
    observe(12);
    check("mid_discarded", 32'(obs_pulses), 32'd0);

    // ops_done wraps after 256 completed operations
    wr_data  = 16'h0F0F;
    wr_valid = 1'b1;
    run      = 1'b1;
    n_ops    = 0;
    seen255  = 1'b0;
    done     = 1'b0;
    for (int i = 0; i < 3000 && !done; i++) begin
      step();
      if (imc_en) n_ops++;
      if (ops_done == 8'd255) seen255 = 1'b1;
      if (n_ops == 256 && !in_flight) done = 1'b1;
    end
    wr_valid = 1'b0;
    run      = 1'b0;
    check("wrap_pulses",    32'(n_ops), 32'd256);
    check("wrap_seen_255",  32'(seen255), 32'h1);
    check("wrap_ops",       32'(ops_done), 32'h0);
    check("wrap_in_flight", 32'(in_flight), 32'h0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
